fc_result_collector: RTL

//   Responder/sink for the fc layer output stream (out_valid/out_rdy, fc_output,
//   fc_out_idx). Buffers one full result vector of N_OUT scores and tracks the

---
 rtl/fc_result_collector.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fc_result_collector.sv
// Buffers one fc result vector, tracks its signed argmax and streams it out bytewise.
// Optional macro FC_COLLECT_ARGMAX_EN appends a 0xA5 / argmax_idx trailer to each stream.
module fc_result_collector #(
    parameter int N_OUT  = 10,
    parameter int IDX_W  = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_valid,
    input  logic [DATA_W-1:0] fc_output,
    input  logic [IDX_W-1:0]  fc_out_idx,
    output logic              out_rdy,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [IDX_W-1:0]  argmax_idx,
    output logic              vec_done,
    output logic              idx_err
);

    localparam int AW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int REC_W = $clog2(N_OUT + 1);

    localparam logic [IDX_W-1:0] N_OUT_I    = IDX_W'(N_OUT);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_OUT - 1);
    localparam logic [REC_W-1:0] N_OUT_R    = REC_W'(N_OUT);
`ifdef FC_COLLECT_ARGMAX_EN
    localparam logic [REC_W-1:0] LAST_REC   = REC_W'(N_OUT);
    localparam logic [2:0]       LAST_SUB   = 3'd1;
`else
    localparam logic [REC_W-1:0] LAST_REC   = REC_W'(N_OUT - 1);
    localparam logic [2:0]       LAST_SUB   = 3'd4;
`endif

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0]        score_mem [N_OUT];
    logic [N_OUT-1:0]         vld;
    logic signed [DATA_W-1:0] max_val;
    logic [IDX_W-1:0]         max_idx;
    logic                     max_seen;

    logic [REC_W-1:0]         rec, rec_nxt;
    logic [2:0]               sub, sub_nxt;

    logic                     accept, idx_ok, last_word;
    logic                     cand_gt;
    logic signed [DATA_W-1:0] cand_val;
    logic [IDX_W-1:0]         cand_idx;
    logic                     launch, byte_fire, last_byte;
    logic [31:0]              rec_word;
    logic [7:0]               byte_nxt;

    assign out_rdy   = (state == COLLECT);
    assign accept    = out_valid & out_rdy;
    assign idx_ok    = (fc_out_idx < N_OUT_I);
    assign last_word = accept && (fc_out_idx == LAST_IDX);
    assign launch    = (state == SEND) && !tx_valid;
    assign byte_fire = tx_valid & tx_ready;
    assign last_byte = (rec == LAST_REC) && (sub == LAST_SUB);

    // Running max includes the word being accepted this cycle so argmax_idx
    // can be latched on the same edge that enters SEND.
    always_comb begin
        cand_gt  = !max_seen || ($signed(fc_output) > max_val);
        cand_val = max_val;
        cand_idx = max_idx;
        if (accept && idx_ok && cand_gt) begin
            cand_val = $signed(fc_output);
            cand_idx = fc_out_idx;
        end
    end

    always_comb begin
        rec_nxt = rec;
        sub_nxt = sub;
        if (byte_fire) begin
            if (sub == 3'd4) begin
                rec_nxt = rec + REC_W'(1);
                sub_nxt = 3'd0;
            end else begin
                sub_nxt = sub + 3'd1;
            end
        end
    end

    always_comb begin
        rec_word = '0;
        if ((rec_nxt < N_OUT_R) && vld[rec_nxt[AW-1:0]])
            rec_word = 32'(score_mem[rec_nxt[AW-1:0]]);
        case (sub_nxt)
            3'd0:    byte_nxt = 8'(rec_nxt);
            3'd1:    byte_nxt = rec_word[31:24];
            3'd2:    byte_nxt = rec_word[23:16];
            3'd3:    byte_nxt = rec_word[15:8];
            3'd4:    byte_nxt = rec_word[7:0];
            default: byte_nxt = '0;
        endcase
`ifdef FC_COLLECT_ARGMAX_EN
        if (rec_nxt == N_OUT_R)
            byte_nxt = (sub_nxt == 3'd0) ? 8'hA5 : 8'(argmax_idx);
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (last_word) state_nxt = SEND;
            SEND:    if (byte_fire && last_byte) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= COLLECT;
        else      state <= state_nxt;
    end

    // Score storage needs no reset: vld gates every read.
    always_ff @(posedge clk) begin
        if (accept && idx_ok)
            score_mem[fc_out_idx[AW-1:0]] <= fc_output;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            argmax_idx <= '0;
            vec_done   <= 1'b0;
            idx_err    <= 1'b0;
            vld        <= '0;
            max_val    <= '0;
            max_idx    <= '0;
            max_seen   <= 1'b0;
            rec        <= '0;
            sub        <= '0;
        end else begin
            vec_done <= 1'b0;
            if (accept && !idx_ok)
                idx_err <= 1'b1;
            if (accept && idx_ok) begin
                vld[fc_out_idx[AW-1:0]] <= 1'b1;
                max_val  <= cand_val;
                max_idx  <= cand_idx;
                max_seen <= 1'b1;
            end
            if (last_word)
                argmax_idx <= cand_idx;
            if (launch || (byte_fire && !last_byte)) begin
                tx_valid <= 1'b1;
                tx_data  <= byte_nxt;
                rec      <= rec_nxt;
                sub      <= sub_nxt;
            end else if (byte_fire) begin
                tx_valid <= 1'b0;
                vec_done <= 1'b1;
                vld      <= '0;
                max_seen <= 1'b0;
                rec      <= '0;
                sub      <= '0;
            end
        end
    end

endmodule
